// File: rtl/tri_point_classifier_if.sv
// Handshake bundle for tri_point_classifier: triangle/point input tuple and
// classification result, each with its own valid/ready pair.
interface tri_point_classifier_if #(
    parameter int COORD_W = 12
);
    logic                        in_valid;
    logic                        in_ready;
    logic signed [COORD_W-1:0]   ax, ay, bx, by, cx, cy, px, py;
    logic                        out_valid;
    logic                        out_ready;
    logic                        out_inside;
    logic                        out_on_edge;
    logic                        out_degenerate;
    logic signed [2*COORD_W+2:0] out_area;

    modport master (
        output in_valid, ax, ay, bx, by, cx, cy, px, py, out_ready,
        input  in_ready, out_valid, out_inside, out_on_edge, out_degenerate, out_area
    );

    modport slave (
        input  in_valid, ax, ay, bx, by, cx, cy, px, py, out_ready,
        output in_ready, out_valid, out_inside, out_on_edge, out_degenerate, out_area
    );
endinterface

// File: rtl/tri_point_classifier.sv
// Sequential point-in-triangle classifier: one shared multiplier pair evaluates
// tri, w0, w1, w2 over four cycles, then holds the registered result until taken.
module tri_point_classifier #(
    parameter int COORD_W     = 12,
    parameter bit INCLUSIVE   = 1'b0,
    parameter bit ORIENT_FREE = 1'b1
) (
    input logic                   clk,
    input logic                   rst,
    tri_point_classifier_if.slave bus
);
    localparam int DIF_W = COORD_W + 1;
    localparam int PRD_W = 2 * COORD_W + 2;
    localparam int D_W   = 2 * COORD_W + 3;

    typedef enum logic [2:0] {IDLE, C0, C1, C2, C3, DONE} state_t;
    state_t state_q, state_d;

    logic signed [COORD_W-1:0] ax_q, ay_q, bx_q, by_q, cx_q, cy_q, px_q, py_q;
    logic signed [D_W-1:0]     tri_q, w0_q, w1_q, area_q;
    logic                      inside_q, on_edge_q, degen_q;

    logic                      accept;
    logic signed [COORD_W-1:0] ux, uy, vx, vy, wx, wy;
    logic signed [DIF_W-1:0]   dvx, dvy, dwx, dwy;
    logic signed [PRD_W-1:0]   prod_a, prod_b;
    logic signed [D_W-1:0]     d_res;

    logic       flip, degen_d, strict_d, edge_d, inside_d;
    logic [2:0] neg, zero, pos, nonneg;

    assign bus.in_ready       = (state_q == IDLE) && !rst;
    assign bus.out_valid      = (state_q == DONE);
    assign bus.out_inside     = inside_q;
    assign bus.out_on_edge    = on_edge_q;
    assign bus.out_degenerate = degen_q;
    assign bus.out_area       = area_q;
    assign accept             = bus.in_valid && bus.in_ready;

    // Operand routing for D(u,v,w): C0 -> (A,B,C), C1 -> (B,C,P), C2 -> (C,A,P), C3 -> (A,B,P)
    always_comb begin
        ux = ax_q; uy = ay_q; vx = bx_q; vy = by_q; wx = px_q; wy = py_q;
        case (state_q)
            C0: begin wx = cx_q; wy = cy_q; end
            C1: begin ux = bx_q; uy = by_q; vx = cx_q; vy = cy_q; end
            C2: begin ux = cx_q; uy = cy_q; vx = ax_q; vy = ay_q; end
            default: ;
        endcase
    end

    assign dvx    = DIF_W'(vx) - DIF_W'(ux);
    assign dvy    = DIF_W'(vy) - DIF_W'(uy);
    assign dwx    = DIF_W'(wx) - DIF_W'(ux);
    assign dwy    = DIF_W'(wy) - DIF_W'(uy);
    assign prod_a = PRD_W'(dvx) * PRD_W'(dwy);
    assign prod_b = PRD_W'(dvy) * PRD_W'(dwx);
    assign d_res  = D_W'(prod_a) - D_W'(prod_b);

    // In C3 the live product is w2; sign flip is applied by swapping the meaning of pos
    always_comb begin
        neg     = {d_res[D_W-1], w1_q[D_W-1], w0_q[D_W-1]};
        zero    = {d_res == '0, w1_q == '0, w0_q == '0};
        flip    = ORIENT_FREE && tri_q[D_W-1];
        pos     = flip ? neg : (~neg & ~zero);
        nonneg  = pos | zero;
        degen_d = (tri_q == '0);
        strict_d = &pos;
        edge_d   = !degen_d && (&nonneg) && (|zero);
        inside_d = !degen_d && (strict_d || (INCLUSIVE && edge_d));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = C0;
            C0:      state_d = C1;
            C1:      state_d = C2;
            C2:      state_d = C3;
            C3:      state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            area_q    <= '0;
            inside_q  <= 1'b0;
            on_edge_q <= 1'b0;
            degen_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                C0: tri_q <= d_res;
                C1: w0_q  <= d_res;
                C2: w1_q  <= d_res;
                C3: begin
                    area_q    <= tri_q;
                    inside_q  <= inside_d;
                    on_edge_q <= edge_d;
                    degen_q   <= degen_d;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            ax_q <= bus.ax; ay_q <= bus.ay;
            bx_q <= bus.bx; by_q <= bus.by;
            cx_q <= bus.cx; cy_q <= bus.cy;
            px_q <= bus.px; py_q <= bus.py;
        end
    end
endmodule

// File: tb/tb_tri_point_classifier.sv
// Directed bench: two instances (INCLUSIVE=0/ORIENT_FREE=1 and INCLUSIVE=1/ORIENT_FREE=0)
// driven in lockstep with hand-computed expectations.
module tb_tri_point_classifier;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    tri_point_classifier_if #(.COORD_W(12)) bus0 ();
    tri_point_classifier_if #(.COORD_W(12)) bus1 ();

    tri_point_classifier #(.COORD_W(12), .INCLUSIVE(1'b0), .ORIENT_FREE(1'b1)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    tri_point_classifier #(.COORD_W(12), .INCLUSIVE(1'b1), .ORIENT_FREE(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int ax, input int ay, input int bx, input int by,
                         input int cx, input int cy, input int px, input int py);
        bus0.ax = 12'(ax); bus0.ay = 12'(ay); bus0.bx = 12'(bx); bus0.by = 12'(by);
        bus0.cx = 12'(cx); bus0.cy = 12'(cy); bus0.px = 12'(px); bus0.py = 12'(py);
        bus1.ax = 12'(ax); bus1.ay = 12'(ay); bus1.bx = 12'(bx); bus1.by = 12'(by);
        bus1.cx = 12'(cx); bus1.cy = 12'(cy); bus1.px = 12'(px); bus1.py = 12'(py);
    endtask

    task automatic handshake(input string tag);
        int n = 0;
        bus0.in_valid = 1'b1;
        bus1.in_valid = 1'b1;
        while (!bus0.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq({tag, "_ready0"}, longint'(bus0.in_ready), 1);
        check_eq({tag, "_ready1"}, longint'(bus1.in_ready), 1);
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        bus1.in_valid = 1'b0;
    endtask

    // Called at #1 after the accepting edge; result must appear 4 edges later.
    task automatic wait_result(input string tag);
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus0.out_valid && n < 20);
        check_eq({tag, "_latency"}, longint'(n), 4);
        check_eq({tag, "_valid1"}, longint'(bus1.out_valid), 1);
    endtask

    task automatic check_out(input string tag, input longint area, input bit deg,
                             input bit ins0, input bit edg0, input bit ins1, input bit edg1);
        check_eq({tag, "_area0"}, longint'(bus0.out_area), area);
        check_eq({tag, "_area1"}, longint'(bus1.out_area), area);
        check_eq({tag, "_deg0"}, longint'(bus0.out_degenerate), longint'(deg));
        check_eq({tag, "_deg1"}, longint'(bus1.out_degenerate), longint'(deg));
        check_eq({tag, "_inside0"}, longint'(bus0.out_inside), longint'(ins0));
        check_eq({tag, "_edge0"}, longint'(bus0.out_on_edge), longint'(edg0));
        check_eq({tag, "_inside1"}, longint'(bus1.out_inside), longint'(ins1));
        check_eq({tag, "_edge1"}, longint'(bus1.out_on_edge), longint'(edg1));
    endtask

    task automatic pop(input string tag);
        bus0.out_ready = 1'b1;
        bus1.out_ready = 1'b1;
        @(posedge clk); #1;
        bus0.out_ready = 1'b0;
        bus1.out_ready = 1'b0;
        check_eq({tag, "_valid_drop"}, longint'(bus0.out_valid), 0);
        check_eq({tag, "_ready_back"}, longint'(bus0.in_ready), 1);
    endtask

    task automatic run_vec(input string tag,
                           input int ax, input int ay, input int bx, input int by,
                           input int cx, input int cy, input int px, input int py,
                           input longint area, input bit deg,
                           input bit ins0, input bit edg0, input bit ins1, input bit edg1);
        drive(ax, ay, bx, by, cx, cy, px, py);
        handshake(tag);
        wait_result(tag);
        check_out(tag, area, deg, ins0, edg0, ins1, edg1);
        pop(tag);
    endtask

    initial begin
        bus0.in_valid = 1'b0; bus1.in_valid = 1'b0;
        bus0.out_ready = 1'b0; bus1.out_ready = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", longint'(bus0.in_ready), 0);
        check_eq("rst_out_valid", longint'(bus0.out_valid), 0);
        rst = 1'b0;
        #1;
        check_eq("post_rst_in_ready", longint'(bus0.in_ready), 1);
        check_eq("post_rst_area", longint'(bus0.out_area), 0);

        // CCW triangle: w = (633, 595, 563)
        run_vec("ccw", 32, 51, 0, 0, 69, 54, 33, 35, 1791, 0, 1, 0, 1, 0);
        // Same triangle wound CW: only the orientation-free instance accepts it
        run_vec("cw", 32, 51, 69, 54, 0, 0, 33, 35, -1791, 0, 1, 0, 0, 0);

        // Backpressure: result held, next tuple waits with in_valid high
        drive(32, 51, 0, 0, 69, 54, 33, 35);
        handshake("bp1");
        wait_result("bp1");
        drive(0, 0, 10, 0, 0, 10, 5, 0);
        bus0.in_valid = 1'b1;
        bus1.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_eq("bp_hold_valid", longint'(bus0.out_valid), 1);
            check_eq("bp_hold_area", longint'(bus0.out_area), 1791);
            check_eq("bp_hold_inside", longint'(bus0.out_inside), 1);
            check_eq("bp_hold_in_ready", longint'(bus0.in_ready), 0);
        end
        pop("bp1");
        handshake("bp2");
        wait_result("bp2");
        check_out("edge_mid", 100, 0, 0, 1, 1, 1);
        pop("bp2");

        run_vec("vertex", 0, 0, 10, 0, 0, 10, 0, 0, 100, 0, 0, 1, 1, 1);
        run_vec("outside", 0, 0, 10, 0, 0, 10, 11, 0, 100, 0, 0, 0, 0, 0);
        run_vec("edge_again", 0, 0, 10, 0, 0, 10, 5, 0, 100, 0, 0, 1, 1, 1);

        // Reset mid-computation (state C1) discards the tuple
        drive(32, 51, 0, 0, 69, 54, 33, 35);
        handshake("rst_mid");
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_eq("rst_mid_in_ready", longint'(bus0.in_ready), 0);
        @(posedge clk); #1;
        check_eq("rst_mid_valid", longint'(bus0.out_valid), 0);
        check_eq("rst_mid_area0", longint'(bus0.out_area), 0);
        check_eq("rst_mid_area1", longint'(bus1.out_area), 0);
        check_eq("rst_mid_edge0", longint'(bus0.out_on_edge), 0);
        check_eq("rst_mid_inside1", longint'(bus1.out_inside), 0);
        check_eq("rst_mid_deg0", longint'(bus0.out_degenerate), 0);
        rst = 1'b0;
        #1;
        check_eq("rst_mid_ready_back", longint'(bus0.in_ready), 1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check_eq("rst_mid_no_ghost", longint'(bus0.out_valid | bus1.out_valid), 0);
        end

        run_vec("degenerate", 0, 0, 5, 5, 10, 10, 5, 5, 0, 1, 0, 0, 0, 0);
        // Full-range coordinates: w0 = -4095, no overflow
        run_vec("extreme", -2048, -2048, 2047, -2048, -2048, 2047, 0, 0, 16769025, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tri_point_classifier.md
Name: tri_point_classifier

Overview:
- Sequential, parametrised point-in-triangle classifier; successor to the combinational area-sign triangle test.
- Takes triangle vertices A, B, C and query point P over a valid/ready handshake.
- Computes the three edge functions and the doubled signed triangle area with one shared multiplier pair over four cycles.
- Returns inside / on-edge / degenerate flags plus the doubled area; optional winding independence and edge inclusion. Feeds the rasteriser / hit-test datapath.

Parameters:
- COORD_W, 12, signed coordinate width (two's complement).
- INCLUSIVE, 0, 1 = points on an edge or vertex report out_inside=1.
- ORIENT_FREE, 1, 1 = accept CW and CCW triangles; 0 = CCW (positive area) only.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input tuple valid.
- in_ready  out  1  block can accept a tuple.
- ax, ay, bx, by, cx, cy, px, py  in  COORD_W each  signed coordinates.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_inside  out  1  classification result.
- out_on_edge  out  1  P on boundary (non-degenerate triangle only).
- out_degenerate  out  1  triangle area is zero.
- out_area  out  2*COORD_W+3  signed D(A,B,C), i.e. twice the signed area.

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high.
- D(u,v,w) = (vx-ux)*(wy-uy) - (vy-uy)*(wx-ux).
- Widths: differences COORD_W+1 bits, products 2*COORD_W+2 bits, D results 2*COORD_W+3 bits, all signed. No overflow is possible at any width; no saturation.
- Edge functions: w0=D(B,C,P), w1=D(C,A,P), w2=D(A,B,P), tri=D(A,B,C). Invariant: w0+w1+w2 == tri.
- FSM states IDLE, C0, C1, C2, C3, DONE.
- IDLE:
  - in_ready = (state==IDLE) && !rst.
  - On in_valid&&in_ready, register all 8 inputs and go to C0.
- C0..C3 compute tri, w0, w1, w2 (one per cycle) into registers; C3 -> DONE.
- Latency and throughput:
  - Handshake at edge k gives out_valid=1 from edge k+4.
  - Minimum spacing is 6 cycles per tuple (DONE handshake -> IDLE -> accept).
- DONE:
  - out_valid=1; all out_* held stable until out_valid&&out_ready, then go to IDLE.
  - Inputs are ignored outside IDLE.
- Classification, registered on the C3 -> DONE edge:
  - s = -1 if ORIENT_FREE && tri<0, else +1; n_i = s*w_i.
  - degenerate = (tri==0); it forces inside=0 and on_edge=0.
  - strict = all n_i>0.
  - on_edge = !degenerate && all n_i>=0 && any n_i==0.
  - out_inside = !degenerate && (strict || (INCLUSIVE && on_edge)).
  - With ORIENT_FREE=0 and tri<0, the sum invariant guarantees inside=0 and on_edge=0.
- Reset:
  - rst in any state (including mid-computation or DONE with out_ready low) gives, next cycle: state=IDLE, out_valid=0, out_inside=0, out_on_edge=0, out_degenerate=0, out_area=0.
  - The in-flight tuple is discarded; in_ready=1 the first cycle rst is low.
- in_valid held with in_ready=0: no effect and no loss; the tuple is accepted when IDLE is reached.

Test Plan:
- A(32,51) B(0,0) C(69,54) P(33,35), defaults -> out_area=1791 (w0=633, w1=595, w2=563), inside=1, on_edge=0, degenerate=0, out_valid exactly 4 cycles after handshake.
- Same triangle with B and C swapped, P(33,35) -> out_area=-1791; ORIENT_FREE=1 gives inside=1; ORIENT_FREE=0 gives inside=0 and on_edge=0.
- A(0,0) B(10,0) C(0,10):
  - P(5,0) -> w=(50,50,0), on_edge=1, inside=INCLUSIVE.
  - P(0,0) -> on_edge=1, inside=INCLUSIVE.
  - P(11,0) -> inside=0, on_edge=0.
- Degenerate and extreme ranges:
  - A(0,0) B(5,5) C(10,10) P(5,5) -> degenerate=1, area=0, inside=0, on_edge=0.
  - COORD_W=12, A(-2048,-2048) B(2047,-2048) C(-2048,2047) P(0,0) -> area=16769025, w0=-4095, inside=0 (no overflow).
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0; release -> one handshake, in_ready=1 next cycle, second tuple result correct.
- Reset: assert rst in C1 -> next cycle out_valid=0, all outputs 0; the discarded tuple never appears; the next tuple completes with 4-cycle latency.
